// File: rtl/fm_normalize_pipe.sv
// Two-stage product normalizer: leading-one detect, implied-1 removal, exponent
// adjust, denormal shift with sticky, zero/overflow flags, valid/ready handshake.
module fm_normalize_pipe #(
    parameter int PRODWIDTH = 48,
    parameter int EXPWIDTH  = 10,
    parameter int EMAX      = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PRODWIDTH-1:0]       prod,
    input  logic signed [EXPWIDTH-1:0] exp_in,
    input  logic                       sticky_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PRODWIDTH-1:0]       normalized,
    output logic signed [EXPWIDTH-1:0] exp_out,
    output logic                       tiny,
    output logic                       zero,
    output logic                       huge,
    output logic                       sticky
);

    localparam int LZW = $clog2(PRODWIDTH + 1);
    localparam int EW1 = EXPWIDTH + 1;
    localparam logic signed [EW1-1:0] EMAX_S = EW1'(EMAX);

    function automatic logic [LZW-1:0] lzc(input logic [PRODWIDTH-1:0] v);
        lzc = LZW'(PRODWIDTH);
        for (int i = 0; i < PRODWIDTH; i++)
            if (v[i]) lzc = LZW'(PRODWIDTH - 1 - i);
    endfunction

    // Right shift saturating at the full width; returns {lost_bits_or, shifted}.
    function automatic logic [PRODWIDTH:0] sat_rshift(input logic [PRODWIDTH-1:0] v,
                                                      input logic [EW1-1:0] amt);
        logic [PRODWIDTH-1:0] mask;
        if (amt >= EW1'(PRODWIDTH)) begin
            sat_rshift = {|v, {PRODWIDTH{1'b0}}};
        end else begin
            mask       = ~({PRODWIDTH{1'b1}} << amt);
            sat_rshift = {|(v & mask), v >> amt};
        end
    endfunction

    logic                       vld_p1, vld_p2;
    logic                       adv1, adv2;
    logic [PRODWIDTH-1:0]       prod_p1;
    logic signed [EXPWIDTH-1:0] exp_p1;
    logic                       sticky_p1;
    logic [LZW-1:0]             lz_p1;

    assign adv2      = !vld_p2 || out_ready;
    assign adv1      = !vld_p1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv1) vld_p1 <= in_valid;
            if (adv2) vld_p2 <= vld_p1;
        end
    end

    // ---- stage 1: capture and leading-zero count
    always_ff @(posedge clk) begin
        if (in_valid && adv1) begin
            prod_p1   <= prod;
            exp_p1    <= exp_in;
            sticky_p1 <= sticky_in;
            lz_p1     <= lzc(prod);
        end
    end

    logic signed [EW1-1:0]       e_n, s_sh, exp_x, lz_s;
    logic [PRODWIDTH:0]          rsh;
    logic [PRODWIDTH-1:0]        norm_d;
    logic signed [EXPWIDTH-1:0]  exp_d;
    logic                        tiny_d, zero_d, huge_d, sticky_d;

    always_comb begin
        exp_x    = EW1'(exp_p1);
        lz_s     = EW1'(lz_p1);
        e_n      = exp_x + EW1'(1) - lz_s;
        s_sh     = exp_x + EW1'(1);
        rsh      = sat_rshift(prod_p1, EW1'(-s_sh));
        norm_d   = '0;
        exp_d    = '0;
        tiny_d   = 1'b0;
        zero_d   = 1'b0;
        huge_d   = 1'b0;
        sticky_d = sticky_p1;
        if (prod_p1 == '0) begin
            zero_d = 1'b1;
        end else if (e_n >= EMAX_S) begin
            huge_d = 1'b1;
            exp_d  = EXPWIDTH'(EMAX);
        end else if (e_n >= EW1'(1)) begin
            norm_d = prod_p1 << (lz_p1 + 1);
            exp_d  = EXPWIDTH'(e_n);
        end else begin
            tiny_d = 1'b1;
            if (s_sh >= EW1'(0)) begin
                norm_d = prod_p1 << $unsigned(s_sh);
            end else begin
                norm_d   = rsh[PRODWIDTH-1:0];
                sticky_d = sticky_p1 | rsh[PRODWIDTH];
            end
        end
    end

    // ---- stage 2: registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            normalized <= '0;
            exp_out    <= '0;
            tiny       <= 1'b0;
            zero       <= 1'b0;
            huge       <= 1'b0;
            sticky     <= 1'b0;
        end else if (vld_p1 && adv2) begin
            normalized <= norm_d;
            exp_out    <= exp_d;
            tiny       <= tiny_d;
            zero       <= zero_d;
            huge       <= huge_d;
            sticky     <= sticky_d;
        end
    end

endmodule

// File: tb/tb_fm_normalize_pipe.sv
// Directed bench for fm_normalize_pipe (W=8, EXPWIDTH=10, EMAX=255).
module tb_fm_normalize_pipe;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        prod;
    logic signed [9:0] exp_in;
    logic              sticky_in;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        normalized;
    logic signed [9:0] exp_out;
    logic              tiny, zero, huge, sticky;

    int checks = 0;
    int errors = 0;

    fm_normalize_pipe #(.PRODWIDTH(8), .EXPWIDTH(10), .EMAX(255)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .prod(prod), .exp_in(exp_in), .sticky_in(sticky_in),
        .out_valid(out_valid), .out_ready(out_ready), .normalized(normalized),
        .exp_out(exp_out), .tiny(tiny), .zero(zero), .huge(huge), .sticky(sticky)
    );

    always #5 clk = ~clk;

    // {out_valid, normalized, exp_out, tiny, zero, huge, sticky}
    logic [22:0] obs;
    assign obs = {out_valid, normalized, exp_out, tiny, zero, huge, sticky};

    typedef struct {
        logic [7:0]  p;
        int          e;
        logic        st;
        logic [22:0] exp_obs;
    } vec_t;

    // Drives one beat and leaves the bench two edges later, where the beat is on the output.
    task automatic send(input logic [7:0] p, input int e, input logic st);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prod      = p;
        exp_in    = 10'(e);
        sticky_in = st;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        prod = '0; exp_in = '0; sticky_in = 1'b0;
        #12;
        checks++;
        if (obs !== 23'h0) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", obs, 23'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; prod = 8'h80; exp_in = 10'sd100; sticky_in = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_t1: out_valid got %b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 8'h00, 10'd101, 4'b0000}) begin
            errors++; $display("FAIL latency_t2: got %h want %h", obs, {1'b1, 8'h00, 10'd101, 4'b0000});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_normal();
        vec_t v[5] = '{
            '{8'h60, 100, 1'b0, {1'b1, 8'h80, 10'd100, 4'b0000}},
            '{8'h60, 100, 1'b1, {1'b1, 8'h80, 10'd100, 4'b0001}},
            '{8'h80, 253, 1'b0, {1'b1, 8'h00, 10'd254, 4'b0000}},
            '{8'h80,   0, 1'b0, {1'b1, 8'h00, 10'd1,   4'b0000}},
            '{8'h0B, 100, 1'b0, {1'b1, 8'h60, 10'd97,  4'b0000}}
        };
        for (int i = 0; i < 5; i++) begin
            send(v[i].p, v[i].e, v[i].st);
            checks++;
            if (obs !== v[i].exp_obs) begin
                errors++; $display("FAIL normal[%0d]: got %h want %h", i, obs, v[i].exp_obs);
            end
        end
    endtask

    task automatic test_denormal();
        vec_t v[5] = '{
            '{8'h10,   2, 1'b0, {1'b1, 8'h80, 10'd0, 4'b1000}},
            '{8'h43,  -3, 1'b0, {1'b1, 8'h10, 10'd0, 4'b1001}},
            '{8'h43, -20, 1'b0, {1'b1, 8'h00, 10'd0, 4'b1001}},
            '{8'h44,  -3, 1'b0, {1'b1, 8'h11, 10'd0, 4'b1000}},
            '{8'h40,  -1, 1'b0, {1'b1, 8'h40, 10'd0, 4'b1000}}
        };
        for (int i = 0; i < 5; i++) begin
            send(v[i].p, v[i].e, v[i].st);
            checks++;
            if (obs !== v[i].exp_obs) begin
                errors++; $display("FAIL denormal[%0d]: got %h want %h", i, obs, v[i].exp_obs);
            end
        end
    endtask

    task automatic test_specials();
        vec_t v[4] = '{
            '{8'h00,  50, 1'b1, {1'b1, 8'h00, 10'd0,   4'b0101}},
            '{8'h00,  -5, 1'b0, {1'b1, 8'h00, 10'd0,   4'b0100}},
            '{8'h80, 255, 1'b0, {1'b1, 8'h00, 10'd255, 4'b0010}},
            '{8'h40, 255, 1'b1, {1'b1, 8'h00, 10'd255, 4'b0011}}
        };
        for (int i = 0; i < 4; i++) begin
            send(v[i].p, v[i].e, v[i].st);
            checks++;
            if (obs !== v[i].exp_obs) begin
                errors++; $display("FAIL special[%0d]: got %h want %h", i, obs, v[i].exp_obs);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ps[6] = '{8'hFF, 8'h55, 8'h0B, 8'h23, 8'h9A, 8'h07};
        logic [7:0] ns[6] = '{8'hFE, 8'h54, 8'h60, 8'h18, 8'h34, 8'hC0};
        int         es[6] = '{101, 100, 97, 99, 101, 96};
        logic [22:0] held = '0;
        logic [22:0] want;
        logic stalled = 1'b0;
        int sent = 0;
        int got  = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 7);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                prod = ps[sent]; exp_in = 10'sd100; sticky_in = 1'b0;
            end
            #1;
            if (stalled) begin
                checks++;
                if (obs !== held) begin
                    errors++; $display("FAIL stall_hold c%0d: got %h want %h", c, obs, held);
                end
            end
            if (c == 5) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL stall_full: in_ready %b out_valid %b want 0 1", in_ready, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                want = {1'b1, ns[got], 10'(es[got]), 4'b0000};
                checks++;
                if (obs !== want) begin
                    errors++; $display("FAIL b2b[%0d]: got %h want %h", got, obs, want);
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = obs;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 6) begin
            errors++; $display("FAIL b2b_count: got %0d beats want 6", got);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; prod = 8'h60; exp_in = 10'sd100; sticky_in = 1'b1;
        @(negedge clk);
        prod = 8'h80;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_prefill: out_valid got %b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 23'h0) begin
            errors++; $display("FAIL midrst_clear: got %h want %h", obs, 23'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_ghost c%0d: out_valid got %b want 0", c, out_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_normal();
        test_denormal();
        test_specials();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
